// File: rtl/toy_trap_seq_if.sv
// toy_trap_seq_if: request, CSR-write and redirect signals of the trap-entry sequencer.
// The master modport drives trap requests, mtvec and redir_rdy. The slave modport is the sequencer side.
interface toy_trap_seq_if #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned REG_WIDTH  = 32
);
   logic [NUM_SRC-1:0]            src_vld;
   logic [NUM_SRC*REG_WIDTH-1:0]  src_cause;
   logic [NUM_SRC*ADDR_WIDTH-1:0] src_pc;
   logic [NUM_SRC*REG_WIDTH-1:0]  src_tval;
   logic [NUM_SRC-1:0]            src_ack;
   logic [REG_WIDTH-1:0]          csr_mtvec;
   logic                          csr_wr_en;
   logic [11:0]                   csr_wr_addr;
   logic [REG_WIDTH-1:0]          csr_wr_data;
   logic                          flush;
   logic                          redir_vld;
   logic                          redir_rdy;
   logic [ADDR_WIDTH-1:0]         redir_pc;
   logic                          busy;

   modport master (
      output src_vld, src_cause, src_pc, src_tval, csr_mtvec, redir_rdy,
      input  src_ack, csr_wr_en, csr_wr_addr, csr_wr_data, flush, redir_vld, redir_pc, busy
   );

   modport slave (
      input  src_vld, src_cause, src_pc, src_tval, csr_mtvec, redir_rdy,
      output src_ack, csr_wr_en, csr_wr_addr, csr_wr_data, flush, redir_vld, redir_pc, busy
   );
endinterface

// File: rtl/toy_trap_seq.sv
// toy_trap_seq: trap-entry sequencer. It grants one of NUM_SRC requesters by fixed priority.
// It writes mepc, mcause and mtval, one per cycle, and then redirects fetch to the mtvec target.
// Only one trap is in flight at a time.
// Optional feature: define TOY_TRAP_SEQ_VECTORED_EN to enable vectored mtvec mode for interrupts.
module toy_trap_seq #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned REG_WIDTH  = 32
) (
   input logic           clk,
   input logic           rst,
   toy_trap_seq_if.slave bus
);

   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVAL  = 12'h343;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_EPC,
      S_WR_CAUSE,
      S_WR_TVAL,
      S_REDIR
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [NUM_SRC-1:0]    w_gnt;
   logic                  w_any;
   logic                  w_take;
   logic [REG_WIDTH-1:0]  w_sel_cause;
   logic [ADDR_WIDTH-1:0] w_sel_pc;
   logic [REG_WIDTH-1:0]  w_sel_tval;
   logic [REG_WIDTH-1:0]  r_cause;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [REG_WIDTH-1:0]  r_tval;
   logic                  r_flush;
   logic [ADDR_WIDTH-1:0] w_base;
   logic [ADDR_WIDTH-1:0] w_target;

   // Fixed-priority pick: the lowest set index wins, and its payload is muxed out
   always_comb begin
      w_gnt       = '0;
      w_any       = 1'b0;
      w_sel_cause = '0;
      w_sel_pc    = '0;
      w_sel_tval  = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (bus.src_vld[i] && !w_any) begin
            w_any       = 1'b1;
            w_gnt[i]    = 1'b1;
            w_sel_cause = bus.src_cause[i*REG_WIDTH +: REG_WIDTH];
            w_sel_pc    = bus.src_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_tval  = bus.src_tval[i*REG_WIDTH +: REG_WIDTH];
         end
      end
   end

   // A grant happens only in IDLE, and never while reset is asserted
   assign w_take = (r_state == S_IDLE) && w_any && !rst;

   // Handler target computation: direct mode, or vectored mode when it is enabled
   always_comb begin
      w_base   = {bus.csr_mtvec[ADDR_WIDTH-1:2], 2'b00};
      w_target = w_base;
`ifdef TOY_TRAP_SEQ_VECTORED_EN
      if (bus.csr_mtvec[1:0] == 2'b01 && r_cause[REG_WIDTH-1]) begin
         w_target = w_base + ADDR_WIDTH'({r_cause[REG_WIDTH-2:0], 2'b00});
      end
`else
      w_target = w_base;
`endif
   end

`ifndef TOY_TRAP_SEQ_VECTORED_EN
   logic [1:0] w_unused_mtvec_mode;
   assign w_unused_mtvec_mode = bus.csr_mtvec[1:0];
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Latch the winning request and raise a one-cycle flush after the grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cause <= '0;
         r_pc    <= '0;
         r_tval  <= '0;
         r_flush <= 1'b0;
      end else begin
         r_flush <= w_take;
         if (w_take) begin
            r_cause <= w_sel_cause;
            r_pc    <= w_sel_pc;
            r_tval  <= w_sel_tval;
         end
      end
   end

   // Next-state logic plus the CSR-write, redirect and ack outputs
   always_comb begin
      w_next          = r_state;
      bus.src_ack     = '0;
      bus.csr_wr_en   = 1'b0;
      bus.csr_wr_addr = '0;
      bus.csr_wr_data = '0;
      bus.redir_vld   = 1'b0;
      bus.redir_pc    = '0;
      bus.busy        = (r_state != S_IDLE);
      bus.flush       = r_flush;
      case (r_state)
         S_IDLE: begin
            if (w_take) begin
               bus.src_ack = w_gnt;
               w_next      = S_WR_EPC;
            end
         end
         S_WR_EPC: begin
            bus.csr_wr_en   = 1'b1;
            bus.csr_wr_addr = CSR_MEPC;
            bus.csr_wr_data = REG_WIDTH'(r_pc);
            w_next          = S_WR_CAUSE;
         end
         S_WR_CAUSE: begin
            bus.csr_wr_en   = 1'b1;
            bus.csr_wr_addr = CSR_MCAUSE;
            bus.csr_wr_data = r_cause;
            w_next          = S_WR_TVAL;
         end
         S_WR_TVAL: begin
            bus.csr_wr_en   = 1'b1;
            bus.csr_wr_addr = CSR_MTVAL;
            bus.csr_wr_data = r_tval;
            w_next          = S_REDIR;
         end
         S_REDIR: begin
            bus.redir_vld = 1'b1;
            bus.redir_pc  = w_target;
            if (bus.redir_rdy) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_toy_trap_seq.sv
// tb_toy_trap_seq: directed scenarios followed by randomized traffic.
// A cycle-count reference model is checked against the DUT on every cycle.
module tb_toy_trap_seq;

   localparam int unsigned NS = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned RW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   toy_trap_seq_if #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) u_if ();

   toy_trap_seq #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   logic [RW-1:0] cause [NS];
   logic [AW-1:0] pc    [NS];
   logic [RW-1:0] tval  [NS];

   always_comb begin
      for (int i = 0; i < NS; i++) begin
         u_if.src_cause[i*RW +: RW] = cause[i];
         u_if.src_pc[i*AW +: AW]    = pc[i];
         u_if.src_tval[i*RW +: RW]  = tval[i];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int first_idx(input logic [NS-1:0] v);
      for (int i = 0; i < NS; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [AW-1:0] target(input logic [RW-1:0] mtvec, input logic [RW-1:0] c);
      logic [AW-1:0] base;
      base = mtvec & ~32'd3;
`ifdef TOY_TRAP_SEQ_VECTORED_EN
      if (mtvec % 4 == 1 && c >= 32'h8000_0000) return base + (c - 32'h8000_0000) * 4;
`endif
      return base;
   endfunction

   // Reference model: a trap in flight is tracked as the number of cycles elapsed since its grant
   bit            m_live = 1'b0;
   bit            m_act  = 1'b0;
   int            m_k    = 0;
   logic [RW-1:0] m_cause, m_tval;
   logic [AW-1:0] m_pc;

   always @(posedge clk) begin
      m_live <= 1'b1;
      if (rst) begin
         m_act <= 1'b0;
         m_k   <= 0;
      end else if (!m_act) begin
         if (u_if.src_vld != '0) begin
            m_act   <= 1'b1;
            m_k     <= 1;
            m_cause <= cause[first_idx(u_if.src_vld)];
            m_pc    <= pc[first_idx(u_if.src_vld)];
            m_tval  <= tval[first_idx(u_if.src_vld)];
         end
      end else if (m_k >= 4) begin
         if (u_if.redir_rdy) begin
            m_act <= 1'b0;
            m_k   <= 0;
         end
      end else begin
         m_k <= m_k + 1;
      end
   end

   // Compare the DUT against the model on every cycle
   always @(negedge clk) begin
      logic [NS-1:0] exp_ack;
      logic [RW-1:0] exp_data;
      if (m_live) begin
         exp_ack = '0;
         if (!m_act && !rst && u_if.src_vld != '0) exp_ack = NS'(1 << first_idx(u_if.src_vld));
         chk("m_ack", u_if.src_ack, exp_ack);
         chk("m_busy", u_if.busy, m_act);
         chk("m_flush", u_if.flush, m_act && m_k == 1);
         chk("m_wr_en", u_if.csr_wr_en, m_act && m_k >= 1 && m_k <= 3);
         if (m_act && m_k >= 1 && m_k <= 3) begin
            exp_data = (m_k == 1) ? m_pc : (m_k == 2) ? m_cause : m_tval;
            chk("m_wr_addr", u_if.csr_wr_addr, 64'h340 + m_k);
            chk("m_wr_data", u_if.csr_wr_data, exp_data);
         end
         chk("m_redir_vld", u_if.redir_vld, m_act && m_k >= 4);
         if (m_act && m_k >= 4) chk("m_redir_pc", u_if.redir_pc, target(u_if.csr_mtvec, m_cause));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_trap(input int idx, input logic [RW-1:0] c, input logic [AW-1:0] p,
                           input logic [RW-1:0] t, output logic [AW-1:0] rpc);
      bit ok;
      cause[idx] = c; pc[idx] = p; tval[idx] = t;
      u_if.src_vld   = NS'(1 << idx);
      u_if.redir_rdy = 1'b1;
      @(negedge clk);
      chk("rt_ack", u_if.src_ack, NS'(1 << idx));
      tick();
      u_if.src_vld = '0;
      ok  = 1'b0;
      rpc = '0;
      for (int n = 0; n < 10 && !ok; n++) begin
         @(negedge clk);
         if (u_if.redir_vld) begin ok = 1'b1; rpc = u_if.redir_pc; end
      end
      chk("rt_redir_seen", ok, 1);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [NS-1:0] acks [2];
      int            ack_cyc [2];
      int            nacks;
      logic [NS-1:0] seen;
      logic [AW-1:0] rpc;
      logic [AW-1:0] exp_vec;
      bit            ok;

      for (int i = 0; i < NS; i++) begin cause[i] = '0; pc[i] = '0; tval[i] = '0; end
      u_if.src_vld   = '0;
      u_if.csr_mtvec = '0;
      u_if.redir_rdy = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", u_if.busy, 0);
      chk("rst_flush", u_if.flush, 0);
      chk("rst_wr_en", u_if.csr_wr_en, 0);
      chk("rst_wr_addr", u_if.csr_wr_addr, 0);
      chk("rst_wr_data", u_if.csr_wr_data, 0);
      chk("rst_redir_vld", u_if.redir_vld, 0);
      chk("rst_redir_pc", u_if.redir_pc, 0);
      chk("rst_ack", u_if.src_ack, 0);

      // Single trap from source 1, with fetch always ready
      tick();
      rst = 1'b0;
      cause[1] = 32'd2; pc[1] = 32'h8000_0100; tval[1] = 32'hDEAD;
      u_if.csr_mtvec = 32'h8000_0000;
      u_if.redir_rdy = 1'b1;
      u_if.src_vld   = 4'b0010;
      @(negedge clk);
      chk("t1_ack", u_if.src_ack, 4'b0010);
      tick(); u_if.src_vld = '0;
      @(negedge clk);
      chk("t1_flush", u_if.flush, 1);
      chk("t1_epc_addr", u_if.csr_wr_addr, 12'h341);
      chk("t1_epc_data", u_if.csr_wr_data, 32'h8000_0100);
      tick(); @(negedge clk);
      chk("t1_flush_off", u_if.flush, 0);
      chk("t1_cause_addr", u_if.csr_wr_addr, 12'h342);
      chk("t1_cause_data", u_if.csr_wr_data, 32'd2);
      tick(); @(negedge clk);
      chk("t1_tval_addr", u_if.csr_wr_addr, 12'h343);
      chk("t1_tval_data", u_if.csr_wr_data, 32'hDEAD);
      tick(); @(negedge clk);
      chk("t1_redir_vld", u_if.redir_vld, 1);
      chk("t1_redir_pc", u_if.redir_pc, 32'h8000_0000);
      tick(); @(negedge clk);
      chk("t1_idle", u_if.busy, 0);

      // Two simultaneous requests: both are served in priority order, five cycles apart
      cause[3] = 32'd6; pc[3] = 32'h0000_2000; tval[3] = 32'h55;
      u_if.src_vld = 4'b1010;
      nacks = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         seen = u_if.src_ack;
         if (seen != '0) begin
            if (nacks < 2) begin acks[nacks] = seen; ack_cyc[nacks] = n; end
            nacks++;
         end
         tick();
         u_if.src_vld = u_if.src_vld & ~seen;
      end
      chk("t2_num_acks", nacks, 2);
      chk("t2_first", acks[0], 4'b0010);
      chk("t2_second", acks[1], 4'b1000);
      chk("t2_gap", ack_cyc[1] - ack_cyc[0], 5);

      // Redirect backpressure: a new request arriving during the stall must wait
      u_if.csr_mtvec = 32'h0000_1000;
      u_if.redir_rdy = 1'b0;
      cause[0] = 32'd11; pc[0] = 32'h40; tval[0] = 32'h0;
      u_if.src_vld = 4'b0001;
      @(negedge clk);
      chk("t3_ack", u_if.src_ack, 4'b0001);
      tick(); u_if.src_vld = '0;
      ok = 1'b0;
      for (int n = 0; n < 10 && !ok; n++) begin
         @(negedge clk);
         if (u_if.redir_vld) ok = 1'b1;
      end
      chk("t3_redir_seen", ok, 1);
      tick();
      cause[2] = 32'd3; pc[2] = 32'h80; tval[2] = 32'h7;
      u_if.src_vld = 4'b0100;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("t3_hold_vld", u_if.redir_vld, 1);
         chk("t3_hold_pc", u_if.redir_pc, 32'h0000_1000);
         chk("t3_hold_busy", u_if.busy, 1);
         chk("t3_hold_noack", u_if.src_ack, 0);
         tick();
      end
      u_if.redir_rdy = 1'b1;
      @(negedge clk);
      chk("t3_hs_vld", u_if.redir_vld, 1);
      tick(); @(negedge clk);
      chk("t3_next_ack", u_if.src_ack, 4'b0100);
      tick(); u_if.src_vld = '0;
      ok = 1'b0;
      for (int n = 0; n < 12 && !ok; n++) begin
         @(negedge clk);
         if (!u_if.busy) ok = 1'b1;
         else tick();
      end
      chk("t3_drain", ok, 1);
      tick();

      // Reset while mcause is being written abandons the trap
      cause[3] = 32'd4; pc[3] = 32'h300; tval[3] = 32'h9;
      u_if.src_vld = 4'b1000;
      @(negedge clk);
      chk("t4_ack", u_if.src_ack, 4'b1000);
      tick(); u_if.src_vld = '0;
      tick(); rst = 1'b1;
      @(negedge clk);
      chk("t4_in_cause", u_if.csr_wr_addr, 12'h342);
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("t4_busy", u_if.busy, 0);
      chk("t4_flush", u_if.flush, 0);
      chk("t4_wr_en", u_if.csr_wr_en, 0);
      chk("t4_wr_addr", u_if.csr_wr_addr, 0);
      chk("t4_wr_data", u_if.csr_wr_data, 0);
      chk("t4_redir_vld", u_if.redir_vld, 0);
      chk("t4_redir_pc", u_if.redir_pc, 0);
      for (int n = 0; n < 8; n++) begin
         tick(); @(negedge clk);
         chk("t4_no_wr", u_if.csr_wr_en, 0);
         chk("t4_no_redir", u_if.redir_vld, 0);
      end
      tick();

      // mtvec mode bits, with an interrupt cause and with an exception cause
      u_if.csr_mtvec = 32'h8000_0001;
`ifdef TOY_TRAP_SEQ_VECTORED_EN
      exp_vec = 32'h8000_001C;
`else
      exp_vec = 32'h8000_0000;
`endif
      run_trap(0, 32'h8000_0007, 32'h1234, 32'h0, rpc);
      chk("t5_irq_pc", rpc, exp_vec);
      run_trap(0, 32'd5, 32'h1238, 32'h0, rpc);
      chk("t5_exc_pc", rpc, 32'h8000_0000);

      // Randomized traffic
      seen = '0;
      for (int n = 0; n < 3000; n++) begin
         u_if.src_vld = u_if.src_vld & ~seen;
         rst = ($urandom % 250 == 0);
         for (int i = 0; i < NS; i++) begin
            if (!u_if.src_vld[i] && $urandom % 8 == 0) begin
               cause[i] = {1'($urandom % 2), 31'($urandom % 64)};
               pc[i]    = $urandom;
               tval[i]  = $urandom;
               u_if.src_vld[i] = 1'b1;
            end else if (u_if.src_vld[i] && $urandom % 64 == 0) begin
               u_if.src_vld[i] = 1'b0;
            end
         end
         u_if.redir_rdy = ($urandom % 3 != 0);
         if (!(m_act && m_k >= 4) && $urandom % 16 == 0) u_if.csr_mtvec = $urandom;
         @(negedge clk);
         seen = u_if.src_ack;
         tick();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
